// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: stalls the pipeline
// for LATENCY+1 cycles per access, then acks with load data or a committed store.
module data_mem_responder #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 256,
    parameter int AW      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_lat_q, err_lat_d;
    logic [31:0]     data_q, data_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic            req;

    logic [31:0]     mem [DEPTH];

    // Address bits above the word index wrap silently.
    logic            unused_addr;
    assign unused_addr = ^Address_i[31:AW+2];

    assign req    = MemRead_i | MemWrite_i;
    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_lat_d = err_lat_q;
        data_d    = data_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        stall_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall_o   = 1'b1;
                    wr_d      = MemWrite_i;
                    addr_d    = Address_i[AW+1:2];
                    wdata_d   = WriteData_i;
                    err_lat_d = (MemRead_i & MemWrite_i) | (|Address_i[1:0]);
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_d = mem[addr_q];
                    end
                    ack_d   = 1'b1;
                    err_d   = err_lat_q;
                    state_d = DONE;
                end
            end
            // Request is still held here until the pipeline edge; ignore it.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            err_lat_q <= 1'b0;
            data_q    <= 32'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_lat_q <= err_lat_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, load/store data,
// error pulses, address wrap and reset abandoning a store.
module tb_data_mem_responder;

    localparam int LAT = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Address_i;
    logic [31:0] WriteData_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    int n_checks = 0;
    int n_fails  = 0;

    data_mem_responder #(
        .LATENCY (LAT),
        .DEPTH   (256),
        .AW      (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Address_i   (Address_i),
        .WriteData_i (WriteData_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .ack_o       (ack_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; leaves inputs idle just after the ack edge.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic chk_data,
                          input logic [31:0] exp_data, input logic glitch);
        int  cycles = 0;
        int  stalls = 0;
        logic got_ack = 1'b0;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        Address_i   = addr;
        WriteData_i = wd;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk_i);
            cycles++;
            if (ack_o) got_ack = 1'b1;
            else if (stall_o) stalls++;
            if (glitch && i == 1) begin
                WriteData_i = ~wd;
                Address_i   = addr ^ 32'h40;
                MemRead_i   = ~rd;
            end
        end
        chk({tag, "_ack"}, 32'(got_ack), 32'd1);
        chk({tag, "_stalls"}, 32'(stalls), 32'(LAT + 1));
        chk({tag, "_cycles"}, 32'(cycles), 32'(LAT + 2));
        chk({tag, "_ack_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
        if (chk_data) chk({tag, "_data"}, data_o, exp_data);
        @(posedge clk_i);
        #1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Address_i   = 32'd0;
        WriteData_i = 32'd0;
    endtask

    initial begin
        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Address_i   = 32'd0;
        WriteData_i = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_ack", 32'(ack_o), 32'd0);
        chk("idle_err", 32'(err_o), 32'd0);
        chk("idle_data", data_o, 32'd0);
        @(posedge clk_i);
        #1;

        access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0);
        access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        access("st20", 1'b0, 1'b1, 32'h20, 32'h1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        access("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
        access("rw08", 1'b1, 1'b1, 32'h08, 32'h55, 1'b1, 1'b1, 32'h1, 1'b0);
        access("ld08", 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0);
        access("ld0a", 1'b1, 1'b0, 32'h0A, 32'h0, 1'b1, 1'b1, 32'h55, 1'b0);
        access("st00", 1'b0, 1'b1, 32'h00, 32'hCAFE0000, 1'b0, 1'b1, 32'h55, 1'b0);
        access("ld400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1, 32'hCAFE0000, 1'b0);
        access("st30", 1'b0, 1'b1, 32'h30, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
        access("ld20b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);

        // Abandon a store of 0xAA to 0x30 with reset while busy.
        MemWrite_i  = 1'b1;
        Address_i   = 32'h30;
        WriteData_i = 32'hAA;
        @(negedge clk_i);
        chk("rst_req_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        chk("rst_busy_stall", 32'(stall_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        MemWrite_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        repeat (4) @(negedge clk_i);
        chk("rst_no_ack", 32'(ack_o), 32'd0);
        @(posedge clk_i);
        #1;
        access("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
